// File: rtl/mvm_pkg.sv
// Shared constants and FSM state type for the 8x8 matrix-vector multiplier
// host-side stream driver and future accelerator revisions.
package mvm_pkg;

  localparam int WIDTH_IN  = 14;
  localparam int WIDTH_OUT = 28;
  localparam int SIZE_X    = 8;
  localparam int SIZE_W    = SIZE_X * SIZE_X;
  localparam int CNT_W     = $clog2(SIZE_W);
  localparam int RCNT_W    = $clog2(SIZE_X);

  typedef enum logic [2:0] {
    IDLE,
    SEND_W,
    SEND_X,
    RECV,
    DONE
  } drv_state_t;

endpackage

// File: rtl/stage_regfile.sv
// Staging register array: synchronous write port, combinational read port.
// Instantiated once for the matrix W and once for the vector x.
module stage_regfile #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 14,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: staging storage is deliberately not reset; the host always fills it
  // before a run, and leaving it reset-free keeps it a plain flop/RAM array.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mvm_stream_driver.sv
// Streams staged W (optional) and x into the multiplier's input port and
// captures its 8 results into a host-readable buffer.
module mvm_stream_driver
  import mvm_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 wr_en,
  input  logic                 wr_sel,
  input  logic [CNT_W-1:0]     wr_addr,
  input  logic [WIDTH_IN-1:0]  wr_data,
  input  logic                 start,
  input  logic                 load_matrix,
  output logic                 busy,
  output logic                 done,
  input  logic [RCNT_W-1:0]    rd_addr,
  output logic [WIDTH_OUT-1:0] rd_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_new_matrix,
  output logic [WIDTH_IN-1:0]  m_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [WIDTH_OUT-1:0] s_data
);

  drv_state_t state, state_next;

  logic [CNT_W-1:0]     cnt;
  logic [RCNT_W-1:0]    rcnt;
  logic                 mat_loaded;
  logic                 m_hs, s_hs;
  logic                 host_wr;
  logic [WIDTH_IN-1:0]  w_rdata, x_rdata;
  logic [WIDTH_OUT-1:0] res [SIZE_X];

  assign m_hs    = m_valid && m_ready;
  assign s_hs    = s_valid && s_ready;
  assign host_wr = wr_en && !busy;

  stage_regfile #(.DEPTH(SIZE_W), .WIDTH(WIDTH_IN)) u_w_buf (
    .clk   (clk),
    .we    (host_wr && wr_sel),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (cnt),
    .rdata (w_rdata)
  );

  stage_regfile #(.DEPTH(SIZE_X), .WIDTH(WIDTH_IN)) u_x_buf (
    .clk   (clk),
    .we    (host_wr && !wr_sel),
    .waddr (wr_addr[RCNT_W-1:0]),
    .wdata (wr_data),
    .raddr (cnt[RCNT_W-1:0]),
    .rdata (x_rdata)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:   if (start) state_next = (load_matrix || !mat_loaded) ? SEND_W : SEND_X;
      SEND_W: if (m_hs && cnt == CNT_W'(SIZE_W - 1)) state_next = SEND_X;
      SEND_X: if (m_hs && cnt == CNT_W'(SIZE_X - 1)) state_next = RECV;
      RECV:   if (s_hs && rcnt == RCNT_W'(SIZE_X - 1)) state_next = DONE;
      DONE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy         = 1'b0;
    done         = 1'b0;
    m_valid      = 1'b0;
    m_new_matrix = 1'b0;
    m_data       = '0;
    unique case (state)
      SEND_W: begin
        busy         = 1'b1;
        m_valid      = 1'b1;
        m_new_matrix = 1'b1;
        m_data       = w_rdata;
      end
      SEND_X: begin
        busy    = 1'b1;
        m_valid = 1'b1;
        m_data  = x_rdata;
      end
      RECV:    busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // s_ready is a flop so it is glitch-free and high for all of RECV.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) s_ready <= 1'b0;
    else          s_ready <= (state_next == RECV);
  end

  // The W counter wraps to 0 on its 64th transfer, ready for the x phase.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt  <= '0;
      rcnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt  <= '0;
          rcnt <= '0;
        end
        SEND_W, SEND_X: if (m_hs) cnt <= cnt + 1'b1;
        RECV:           if (s_hs) rcnt <= rcnt + 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      mat_loaded <= 1'b0;
    else if (state == SEND_W && m_hs && cnt == CNT_W'(SIZE_W - 1))
      mat_loaded <= 1'b1;
  end

  // Unlike the staging buffers, results are visible to the host and must read
  // back as zero after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SIZE_X; i++) res[i] <= '0;
      rd_data <= '0;
    end else begin
      if (state == RECV && s_hs) res[rcnt] <= s_data;
      rd_data <= res[rd_addr];
    end
  end

endmodule

// File: tb/tb_mvm_stream_driver.sv
// Randomized self-checking bench for mvm_stream_driver against a queue-based
// model of the expected input stream and result buffer.
module tb_mvm_stream_driver;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wr_en, wr_sel, start, load_matrix;
  logic [5:0]  wr_addr;
  logic [13:0] wr_data;
  logic        busy, done;
  logic [2:0]  rd_addr;
  logic [27:0] rd_data;
  logic        m_valid, m_ready, m_new_matrix;
  logic [13:0] m_data;
  logic        s_valid, s_ready;
  logic [27:0] s_data;

  int tests_run = 0;
  int failed    = 0;

  logic [13:0] w_mem [64];
  logic [13:0] x_mem [8];
  logic [27:0] stub_res [8];
  bit          model_mat;

  logic [14:0] xfer_q [$];
  int          stall_err;
  logic        prev_stall;
  logic [14:0] prev_word;

  always #5 clk = ~clk;

  mvm_stream_driver dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .wr_en        (wr_en),
    .wr_sel       (wr_sel),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .start        (start),
    .load_matrix  (load_matrix),
    .busy         (busy),
    .done         (done),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_new_matrix (m_new_matrix),
    .m_data       (m_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data)
  );

  // Inputs change #1 after posedge, so the negedge sees what the next edge will.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (m_valid !== 1'b1 || {m_new_matrix, m_data} !== prev_word))
        stall_err++;
      if (m_valid === 1'b1 && m_ready === 1'b1)
        xfer_q.push_back({m_new_matrix, m_data});
      prev_stall = (m_valid === 1'b1 && m_ready !== 1'b1);
      prev_word  = {m_new_matrix, m_data};
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic write_word(input bit sel, input int addr, input logic [13:0] data);
    wr_en = 1'b1; wr_sel = sel; wr_addr = 6'(addr); wr_data = data;
    step();
    wr_en = 1'b0;
    if (sel) w_mem[addr] = data;
    else     x_mem[addr] = data;
  endtask

  // Drives one complete run with an accelerator stub and checks the stream,
  // done timing and result buffer. exp_done < 0 skips the exact latency check.
  task automatic do_run(input bit lm, input bit rnd_ready, input int s_gap,
                        input bit spurious, input bit inject, input bit same_write,
                        input logic [13:0] sw_data, input int exp_done);
    logic [14:0] exp_q [$];
    int          cyc, k, g, n;
    bit          eff, seen_done;
    eff = lm || !model_mat;
    xfer_q.delete();
    stall_err = 0;
    start = 1'b1; load_matrix = lm;
    if (same_write) begin
      wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 6'd3; wr_data = sw_data;
      x_mem[3] = sw_data;
    end
    step();
    start = 1'b0; load_matrix = 1'b0; wr_en = 1'b0;
    if (eff) for (int i = 0; i < 64; i++) exp_q.push_back({1'b1, w_mem[i]});
    for (int j = 0; j < 8; j++) exp_q.push_back({1'b0, x_mem[j]});

    tests_run++;
    if (busy !== 1'b1 || m_valid !== 1'b1) begin
      failed++;
      $display("FAIL run_start_latency: busy=%b m_valid=%b, required 1 1", busy, m_valid);
    end

    k = 0; g = 0; seen_done = 1'b0; cyc = 0;
    for (cyc = 0; cyc < 3000; cyc++) begin
      if (done === 1'b1) begin
        seen_done = 1'b1;
        break;
      end
      m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      s_valid = 1'b0; s_data = '0;
      if (s_ready === 1'b1) begin
        if (g == 0 && k < 8) begin
          s_valid = 1'b1; s_data = stub_res[k]; k++;
        end
        g = (g + 1) % s_gap;
      end else if (spurious && cyc % 3 == 1) begin
        s_valid = 1'b1; s_data = 28'h5A5A5A5;
      end
      start   = inject && (cyc == 10);
      wr_en   = inject && (cyc == 10 || cyc == 12);
      wr_sel  = (cyc == 10);
      wr_addr = (cyc == 10) ? 6'd5 : 6'd2;
      wr_data = 14'h2AAA;
      step();
    end
    start = 1'b0; wr_en = 1'b0; s_valid = 1'b0; m_ready = 1'b1;

    tests_run++;
    if (!seen_done) begin
      failed++;
      $display("FAIL run_done_timeout: no done within %0d cycles", cyc);
      return;
    end
    if (exp_done >= 0) begin
      tests_run++;
      if (cyc != exp_done) begin
        failed++;
        $display("FAIL done_cycle: done after %0d cycles, required %0d", cyc, exp_done);
      end
    end
    tests_run++;
    if (busy !== 1'b0) begin
      failed++;
      $display("FAIL busy_at_done: busy=%b, required 0", busy);
    end

    rd_addr = 3'd7;
    step();
    tests_run++;
    if (done !== 1'b0 || rd_data !== stub_res[7]) begin
      failed++;
      $display("FAIL read_in_done_cycle: done=%b rd_data=%0d, required 0 %0d",
               done, $signed(rd_data), $signed(stub_res[7]));
    end

    tests_run++;
    if (xfer_q.size() != exp_q.size()) begin
      failed++;
      $display("FAIL stream_length: %0d words sent, required %0d", xfer_q.size(), exp_q.size());
    end
    n = (xfer_q.size() < exp_q.size()) ? xfer_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      tests_run++;
      if (xfer_q[i] !== exp_q[i]) begin
        failed++;
        $display("FAIL stream_word[%0d]: got nm=%b d=%h, required nm=%b d=%h",
                 i, xfer_q[i][14], xfer_q[i][13:0], exp_q[i][14], exp_q[i][13:0]);
      end
    end
    tests_run++;
    if (stall_err != 0) begin
      failed++;
      $display("FAIL stall_stability: %0d unstable stalled cycles, required 0", stall_err);
    end

    for (int a = 0; a < 8; a++) begin
      rd_addr = 3'(a);
      step();
      tests_run++;
      if (rd_data !== stub_res[a]) begin
        failed++;
        $display("FAIL result[%0d]: got %0d, required %0d", a, $signed(rd_data), $signed(stub_res[a]));
      end
    end
    if (eff) model_mat = 1'b1;
  endtask

  task automatic test_reset();
    tests_run++;
    if ({busy, done, m_valid, m_new_matrix, s_ready} !== 5'b0 || m_data !== '0 || rd_data !== '0) begin
      failed++;
      $display("FAIL reset_outputs: busy=%b done=%b mv=%b nm=%b sr=%b md=%h rd=%h, required all 0",
               busy, done, m_valid, m_new_matrix, s_ready, m_data, rd_data);
    end
  endtask

  task automatic test_full_run();
    for (int i = 0; i < 64; i++) write_word(1'b1, i, 14'(i - 32));
    for (int j = 0; j < 8; j++)  write_word(1'b0, j, 14'(j + 1));
    for (int k = 0; k < 8; k++)  stub_res[k] = 28'(100 + k);
    do_run(1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, '0, 72 + 8);
  endtask

  task automatic test_matrix_reuse();
    for (int k = 0; k < 8; k++) stub_res[k] = 28'($urandom);
    do_run(1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b1, 14'($urandom), 8 + 8);
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 64; i++) write_word(1'b1, i, 14'($urandom));
    for (int j = 0; j < 8; j++)  write_word(1'b0, j, 14'($urandom));
    for (int k = 0; k < 8; k++)  stub_res[k] = 28'($urandom);
    do_run(1'b1, 1'b1, 1, 1'b0, 1'b0, 1'b0, '0, -1);
    do_run(1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0, '0, -1);
  endtask

  task automatic test_slow_consumer();
    for (int k = 0; k < 8; k++) stub_res[k] = 28'($urandom);
    stub_res[2] = 28'h7FFFFFF;
    stub_res[5] = 28'h8000000;
    do_run(1'b0, 1'b0, 5, 1'b1, 1'b0, 1'b0, '0, -1);
  endtask

  task automatic test_busy_guard();
    int busy_cycles, sent;
    for (int k = 0; k < 8; k++) stub_res[k] = 28'($urandom);
    do_run(1'b0, 1'b0, 1, 1'b0, 1'b1, 1'b0, '0, 8 + 8);
    sent = xfer_q.size();
    busy_cycles = 0;
    for (int c = 0; c < 5; c++) begin
      if (busy !== 1'b0) busy_cycles++;
      step();
    end
    tests_run++;
    if (busy_cycles != 0 || xfer_q.size() != sent) begin
      failed++;
      $display("FAIL busy_start_ignored: %0d busy cycles, %0d extra words, required 0 0",
               busy_cycles, xfer_q.size() - sent);
    end
    do_run(1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, '0, 72 + 8);
  endtask

  task automatic test_reset_midrun();
    start = 1'b1; load_matrix = 1'b0;
    step();
    start = 1'b0;
    step(); step(); step();
    reset_n = 1'b0;
    #1;
    tests_run++;
    if ({busy, done, m_valid, m_new_matrix, s_ready} !== 5'b0 || m_data !== '0 || rd_data !== '0) begin
      failed++;
      $display("FAIL midrun_reset_outputs: busy=%b done=%b mv=%b nm=%b sr=%b md=%h rd=%h, required all 0",
               busy, done, m_valid, m_new_matrix, s_ready, m_data, rd_data);
    end
    step();
    reset_n = 1'b1;
    model_mat = 1'b0;
    for (int a = 0; a < 8; a++) begin
      rd_addr = 3'(a);
      step();
      tests_run++;
      if (rd_data !== '0) begin
        failed++;
        $display("FAIL result_cleared[%0d]: got %h, required 0", a, rd_data);
      end
    end
    for (int k = 0; k < 8; k++) stub_res[k] = 28'($urandom);
    do_run(1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, '0, 72 + 8);
  endtask

  initial begin
    reset_n = 1'b0;
    wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; load_matrix = 1'b0; rd_addr = '0;
    m_ready = 1'b1; s_valid = 1'b0; s_data = '0;
    model_mat = 1'b0;
    prev_stall = 1'b0; prev_word = '0; stall_err = 0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    reset_n = 1'b1;
    step();
    test_full_run();
    test_matrix_reuse();
    test_backpressure();
    test_slow_consumer();
    test_busy_guard();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule

// File: doc/mvm_stream_driver.md
# mvm_stream_driver

Host-side transmitter and collector for the 8x8 matrix-vector multiplier's streaming port. The host fills staging buffers with a 64-word matrix W (row-major) and an 8-word vector x, then pulses `start`. The block then streams W (optional) and x into the accelerator's `input_valid`/`input_ready`/`new_matrix` port and captures the 8 results from its `output_valid`/`output_ready` port into a readable result buffer. It sits between the host register interface and the multiplier's input and output streams.

## Interface
- `WIDTH_IN`, 14, input word width (matrix and vector elements, signed)
- `WIDTH_OUT`, 28, result word width (signed)
- `SIZE_X`, 8, vector length and number of result rows
- `SIZE_W`, 64, matrix word count (`SIZE_X*SIZE_X`)

Ports:
- `clk` in 1: single clock, rising edge
- `reset_n` in 1: asynchronous, active-low reset
- `wr_en` in 1: host write strobe to the staging buffers
- `wr_sel` in 1: 0 = x buffer, 1 = W buffer
- `wr_addr` in 6: staging address; x uses bits [2:0] only
- `wr_data` in `WIDTH_IN`: staging write data
- `start` in 1: one-cycle request to run one multiply
- `load_matrix` in 1: sampled with `start`; 1 = send W before x
- `busy` out 1: run in progress
- `done` out 1: one-cycle pulse when all 8 results are captured
- `rd_addr` in 3: result buffer read address
- `rd_data` out `WIDTH_OUT`: result at `rd_addr`, registered
- `m_valid` out 1: connects to accelerator `input_valid`
- `m_ready` in 1: connects to accelerator `input_ready`
- `m_new_matrix` out 1: connects to accelerator `new_matrix`
- `m_data` out `WIDTH_IN`: connects to accelerator `input_data`
- `s_valid` in 1: connects to accelerator `output_valid`
- `s_ready` out 1: connects to accelerator `output_ready`
- `s_data` in `WIDTH_OUT`: connects to accelerator `output_data`

## Operation
- **FSM states:** IDLE, SEND_W, SEND_X, RECV, DONE.
- **IDLE**
  - Host writes are accepted.
  - On `start`, go to SEND_W if the effective `load_matrix` is 1, otherwise go to SEND_X.
  - Clear the send counter (6 b) and the receive counter (3 b).
- **Effective `load_matrix`:** a `mat_loaded` flag is cleared by reset and set when a W phase completes. If `start` arrives with `load_matrix=0` while `mat_loaded=0`, the run is treated as `load_matrix=1`.
- **SEND_W**
  - `m_valid=1`, `m_new_matrix=1`, `m_data=W[cnt]`.
  - A transfer occurs on `m_valid&&m_ready`; each transfer increments `cnt`.
  - The transfer at `cnt=63` wraps `cnt` to 0 and goes to SEND_X.
- **SEND_X**
  - `m_valid=1`, `m_new_matrix=0`, `m_data=x[cnt]`.
  - The transfer at `cnt=7` goes to RECV.
- **RECV**
  - `m_valid=0`, `s_ready=1`.
  - Each `s_valid&&s_ready` writes `s_data` into `res[rcnt]` and increments `rcnt`.
  - The transfer at `rcnt=7` goes to DONE.
- **DONE:** `done=1` for one cycle, then go to IDLE.
- **Data stability:** while `m_valid=1` and `m_ready=0`, `m_data` and `m_new_matrix` are held stable.
- **Width rules:** data is passed through with no arithmetic or width change. Results are stored exactly as received.
- **Boundary conditions**
  - `start` while `busy`: ignored.
  - `wr_en` while `busy`: ignored, buffers unchanged.
  - `wr_en` and `start` in the same IDLE cycle: the write lands first and is included in the run.
  - `s_valid` outside RECV: ignored (`s_ready=0`).
  - `reset_n` low mid-run: the FSM returns to IDLE immediately and the run is abandoned.
- **Reset values:** `busy=0`, `done=0`, `m_valid=0`, `m_new_matrix=0`, `m_data=0`, `s_ready=0`, `rd_data=0`, `res[*]=0`, `mat_loaded=0`. Staging buffers are not reset.

## Timing
- `start` sampled at edge T: `busy` and `m_valid` are high from T+1.
- With `m_ready` held high:
  - the W phase takes 64 cycles;
  - the x phase takes 8 cycles;
  - `m_valid` is continuous across the W-to-x boundary with no bubble.
- `done` is asserted in the cycle after the 8th result handshake. `busy` falls in the same cycle as `done`.
- `rd_data` has one cycle of latency from `rd_addr`. A read issued in the `done` cycle returns the new result.
- `m_data` is a combinational read of the register array, selected by state and `cnt`.
- `s_ready` is a registered state decode, so it is high for the whole of RECV.

## Structure
- **Package `mvm_pkg`:** `WIDTH_IN`, `WIDTH_OUT`, `SIZE_X`, `SIZE_W` localparams and the FSM state typedef (`drv_state_t`). These are shared with future accelerator revisions.
- **Sub-module `stage_regfile`:** parameterised flop array with synchronous write and combinational read. It is instantiated twice, for W (64 words) and x (8 words).
- **Result buffer:** inline, 8 x `WIDTH_OUT` flops.

## Test plan
- **Full run:** load W[i]=i−32 and x[j]=j+1, `start` with `load_matrix=1`, `m_ready` always 1. Expect exactly 64 transfers with `m_new_matrix=1`, then 8 with `m_new_matrix=0`, in order. A stub returning s=100+k gives `res[k]=100+k` and `done` at the expected cycle.
- **Backpressure:** `m_ready` toggled pseudo-randomly. Expect no word dropped or duplicated, and `m_data` stable while stalled.
- **Matrix reuse:** a second `start` with `load_matrix=0` sends only 8 words. Immediately after reset, the same request sends 72 words.
- **Slow consumer:** `s_valid` pulses every 5 cycles, with a spurious `s_valid` asserted before RECV. Expect only the 8 in-RECV results captured; `res` holds max positive 134217727 and min −134217728 unmodified.
- **Busy guard:** `start` and `wr_en` mid-run are ignored, and the buffers still read back the original values.
- **Reset mid-run:** assert `reset_n`=0 during SEND_X. Expect all outputs at reset values on the next sample and `mat_loaded=0`. A subsequent `start` with `load_matrix=0` sends 72 words.
